// File: rtl/gcm_tag_gen.sv
// gcm_tag_gen: GCM tag sequencer around an external GHASH multiply stage.
// Absorbs AAD/ciphertext blocks (zero-padding partial blocks), tracks the
// AAD and ciphertext bit lengths, hashes the final length block and XORs
// the result with E(K,J0) to form the authentication tag.
// Optional build macro: GCM_TAG_ORDER_CHECK_EN adds a sticky err flag that
// is raised when an AAD block follows a ciphertext block in one message.
module gcm_tag_gen #(
    parameter int GHASH_BITS = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  blk_valid,
    output logic                  blk_ready,
    input  logic [GHASH_BITS-1:0] blk_data,
    input  logic                  blk_is_aad,
    input  logic [4:0]            blk_bytes,
    input  logic                  finish,
    input  logic [GHASH_BITS-1:0] ej0,
    output logic                  gh_en,
    output logic [GHASH_BITS-1:0] gh_g_prev,
    output logic [GHASH_BITS-1:0] gh_data,
    input  logic [GHASH_BITS-1:0] gh_result,
    input  logic                  gh_done,
    output logic [GHASH_BITS-1:0] tag,
    output logic                  tag_valid,
    output logic                  busy,
    output logic                  err
);

    localparam int BYTES_PER_BLK = GHASH_BITS / 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ABSORB   = 3'd1,
        HASH     = 3'd2,
        LEN      = 3'd3,
        LEN_WAIT = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [GHASH_BITS-1:0] hash_acc_reg;
    logic [GHASH_BITS-1:0] ej0_reg;
    logic [63:0]           aad_bits_reg;
    logic [63:0]           ct_bits_reg;
    logic                  gh_en_reg;
    logic [GHASH_BITS-1:0] gh_g_prev_reg;
    logic [GHASH_BITS-1:0] gh_data_reg;
    logic [GHASH_BITS-1:0] tag_reg;
    logic                  tag_valid_reg;

    // Handshake qualifiers. start overrides every other input in the cycle
    // it is seen, so none of these fire alongside it.
    logic blk_accept;
    logic fin_accept;
    logic hash_done;
    logic len_done;

    assign blk_accept = (state_reg == ABSORB) && blk_valid && !start;
    assign fin_accept = (state_reg == ABSORB) && finish && !blk_valid && !start;
    assign hash_done  = (state_reg == HASH) && gh_done && !start;
    assign len_done   = (state_reg == LEN_WAIT) && gh_done && !start;

    // Effective byte count: 0 and anything above a full block mean "full".
    logic [4:0] eff_bytes;
    assign eff_bytes = ((blk_bytes == 5'd0) || (blk_bytes > 5'(BYTES_PER_BLK)))
                       ? 5'(BYTES_PER_BLK) : blk_bytes;

    // Bit count of the accepted block, zero-extended to the counter width.
    logic [63:0] blk_bits;
    assign blk_bits = {56'd0, eff_bytes, 3'b000};

    // Byte 0 sits in the top byte lane; lanes at or past eff_bytes are zeroed.
    logic [GHASH_BITS-1:0] padded_data;
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_BLK; gi = gi + 1) begin : g_pad
            assign padded_data[GHASH_BITS-1-8*gi -: 8] =
                (eff_bytes > 5'(gi)) ? blk_data[GHASH_BITS-1-8*gi -: 8] : 8'h00;
        end
    endgenerate

    // Length block in the order the GHASH stage expects: AAD length first.
    logic [GHASH_BITS-1:0] len_block;
    assign len_block = {aad_bits_reg, ct_bits_reg};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start forces a fresh message from any state.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                state_next = IDLE;
            end
            ABSORB: begin
                if (blk_accept) begin
                    state_next = HASH;
                end else if (fin_accept) begin
                    state_next = LEN;
                end
            end
            HASH: begin
                if (gh_done) begin
                    state_next = ABSORB;
                end
            end
            LEN: begin
                state_next = LEN_WAIT;
            end
            LEN_WAIT: begin
                if (gh_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (start) begin
            state_next = ABSORB;
        end
    end

    // Running hash: cleared per message, updated only by a block result.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            hash_acc_reg <= '0;
        end else if (hash_done) begin
            hash_acc_reg <= gh_result;
        end
    end

    // AAD / ciphertext bit counters, wrapping naturally at 64 bits.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            aad_bits_reg <= '0;
            ct_bits_reg  <= '0;
        end else if (blk_accept) begin
            if (blk_is_aad) begin
                aad_bits_reg <= aad_bits_reg + blk_bits;
            end else begin
                ct_bits_reg <= ct_bits_reg + blk_bits;
            end
        end
    end

    // GHASH request: one-cycle gh_en, operands held until the next request.
    always_ff @(posedge clk) begin
        if (reset) begin
            gh_en_reg     <= 1'b0;
            gh_g_prev_reg <= '0;
            gh_data_reg   <= '0;
        end else begin
            gh_en_reg <= 1'b0;
            if (blk_accept) begin
                gh_en_reg     <= 1'b1;
                gh_g_prev_reg <= hash_acc_reg;
                gh_data_reg   <= padded_data;
            end else if (fin_accept) begin
                gh_en_reg     <= 1'b1;
                gh_g_prev_reg <= hash_acc_reg;
                gh_data_reg   <= len_block;
            end
        end
    end

    // E(K,J0) is captured with finish so the caller may change ej0 afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            ej0_reg <= '0;
        end else if (fin_accept) begin
            ej0_reg <= ej0;
        end
    end

    // Tag register and its one-cycle valid strobe; tag holds between messages.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_reg       <= '0;
            tag_valid_reg <= 1'b0;
        end else begin
            tag_valid_reg <= 1'b0;
            if (len_done) begin
                tag_reg       <= gh_result ^ ej0_reg;
                tag_valid_reg <= 1'b1;
            end
        end
    end

`ifdef GCM_TAG_ORDER_CHECK_EN
    logic seen_ct_reg;
    logic err_reg;

    // Order check: any AAD block after a ciphertext block sets a sticky error;
    // the block itself is still hashed normally.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            seen_ct_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else if (blk_accept) begin
            if (!blk_is_aad) begin
                seen_ct_reg <= 1'b1;
            end else if (seen_ct_reg) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign blk_ready = (state_reg == ABSORB);
    assign busy      = (state_reg != IDLE);
    assign gh_en     = gh_en_reg;
    assign gh_g_prev = gh_g_prev_reg;
    assign gh_data   = gh_data_reg;
    assign tag       = tag_reg;
    assign tag_valid = tag_valid_reg;

endmodule

// File: doc/gcm_tag_gen.md
GCM_TAG_GEN -- requirements
Module: gcm_tag_gen

Interface
REQ-001 SHALL have parameter GHASH_BITS, default 128, GHASH block/tag width (only 128 supported).
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  in  1  one-cycle pulse that opens a new message.
REQ-005 SHALL have port: blk_valid  in  1  input block offered.
REQ-006 SHALL have port: blk_ready  out  1  block can be accepted.
REQ-007 SHALL have port: blk_data  in  128  AAD or ciphertext block, byte 0 at bits [127:120].
REQ-008 SHALL have port: blk_is_aad  in  1  1 means AAD, 0 means ciphertext.
REQ-009 SHALL have port: blk_bytes  in  5  valid bytes in the block; legal range 1..16.
REQ-010 SHALL have port: finish  in  1  request tag computation.
REQ-011 SHALL have port: ej0  in  128  E(K,J0), sampled when finish is accepted.
REQ-012 SHALL have port: gh_en  out  1  one-cycle start pulse to the ghash stage.
REQ-013 SHALL have port: gh_g_prev  out  128  running hash sent to the ghash stage.
REQ-014 SHALL have port: gh_data  out  128  padded block or length block.
REQ-015 SHALL have port: gh_result  in  128  ghash output.
REQ-016 SHALL have port: gh_done  in  1  ghash completion pulse.
REQ-017 SHALL have port: tag  out  128  final authentication tag.
REQ-018 SHALL have port: tag_valid  out  1  one-cycle pulse; tag is valid in this cycle.
REQ-019 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-020 SHALL have port: err  out  1  sticky ordering error.

Function
REQ-021 SHALL implement states IDLE, ABSORB, HASH, LEN, LEN_WAIT and DONE.
REQ-022 SHALL, on start in any state, clear hash_acc, aad_bits, ct_bits and err, then enter ABSORB on the next cycle. start takes priority over every other input.
REQ-023 SHALL drive blk_ready=1 only in ABSORB.
REQ-024 SHALL, on blk_valid&&blk_ready:
- zero blk_data bytes at index blk_bytes..15;
- add 8*blk_bytes to aad_bits if blk_is_aad, otherwise to ct_bits;
- assert gh_en for one cycle on the next cycle, with gh_g_prev=hash_acc and gh_data=padded block;
- enter HASH.
REQ-025 SHALL treat blk_bytes of 0 or greater than 16 as 16.
REQ-026 SHALL use 64-bit length counters that wrap modulo 2^64.
REQ-027 SHALL, in HASH on gh_done, load hash_acc<=gh_result and return to ABSORB.
REQ-028 SHALL accept finish in ABSORB only when blk_valid=0. When blk_valid and finish are both high, the block is accepted and finish is ignored.
REQ-029 SHALL, on accepted finish, latch ej0 and enter LEN.
REQ-030 SHALL, in LEN, pulse gh_en with gh_g_prev=hash_acc and gh_data={aad_bits,ct_bits}, then enter LEN_WAIT.
REQ-031 SHALL, in LEN_WAIT on gh_done, register tag<=gh_result^ej0_reg and tag_valid=1 for exactly one cycle, then enter DONE.
REQ-032 SHALL leave DONE for IDLE on the next cycle.
REQ-033 SHALL hold tag until the next tag_valid or reset.
REQ-034 SHALL ignore gh_done outside HASH and LEN_WAIT.
REQ-035 SHALL ignore blk_valid and finish in IDLE, HASH, LEN, LEN_WAIT and DONE.
REQ-036 SHALL, on start mid-HASH or mid-LEN_WAIT, discard the in-flight ghash result (handled by REQ-034).
REQ-037 SHALL hold gh_g_prev and gh_data stable from the gh_en cycle until gh_done.

Reset
REQ-038 SHALL, on reset, enter IDLE with tag=0, tag_valid=0, gh_en=0, gh_g_prev=0, gh_data=0, blk_ready=0, busy=0, err=0, hash_acc=0 and both counters 0.
REQ-039 SHALL give reset priority over start.

Configuration
REQ-040 SHALL, with GCM_TAG_ORDER_CHECK_EN defined, set err=1 when an AAD block is accepted after any ciphertext block of the same message. The block is still hashed, and err stays set until start or reset.
REQ-041 SHALL, without GCM_TAG_ORDER_CHECK_EN, tie err to 0 and include no ordering logic.

Verification
REQ-042 SHALL cover the following directed scenarios, each using H=66e94bd4ef8a2c3b884cfa59ca342b2e with a real ghash stage:
- Empty message: start, then finish with ej0=58e2fccefa7e3061367f1d57a4e7455a -> gh_data=0, tag=58e2fccefa7e3061367f1d57a4e7455a, one tag_valid pulse.
- One ciphertext block 0388dace60b6a392f328c2b971b2fe78, blk_bytes=16, then finish with the same ej0 -> length block 0...0080, tag=ab6e47d42cec13bdf53a67b21257bddf.
- Partial block with blk_bytes=5 and blk_data all-FF -> gh_data=ffffffffff000000...00 and ct_bits=40.
- blk_valid held high with finish asserted in the same cycle -> block accepted first, no tag. Finish reasserted afterwards -> tag produced.
- start asserted while in HASH, with gh_done arriving a cycle later -> hash_acc stays 0, state ABSORB, no tag_valid.
- With GCM_TAG_ORDER_CHECK_EN, send a ciphertext block then an AAD block -> err=1 until the next start. Without the macro, err stays 0.
